// File: rtl/biquad_coeff_loader_if.sv
// Byte stream carrying coefficient frames into the loader (valid/ready handshake).
interface biquad_coeff_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/biquad_coeff_loader.sv
// Receives byte-serial biquad coefficient frames, verifies the XOR checksum and
// commits all six coefficients to the lpf on the same edge.
module biquad_coeff_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] RST_B0         = 32'd1,
    parameter logic [31:0] RST_A0         = 32'd10000,
    parameter logic [31:0] RST_OTHER      = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    biquad_coeff_loader_if.slave bus,
    output logic [31:0]          b0,
    output logic [31:0]          b1,
    output logic [31:0]          b2,
    output logic [31:0]          a0,
    output logic [31:0]          a1,
    output logic [31:0]          a2,
    output logic                 coeff_update,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy
);
    localparam int unsigned NCOEF = 6;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0]    LAST_PAYLOAD = 5'd23;
    localparam logic [TW-1:0] TO_LAST      = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    // Packed index order: 0=b0, 1=b1, 2=b2, 3=a0, 4=a1, 5=a2
    localparam logic [NCOEF-1:0][31:0] COEF_RST =
        {RST_OTHER, RST_OTHER, RST_A0, RST_OTHER, RST_OTHER, RST_B0};

    logic [1:0]              state, state_d;
    logic [4:0]              cnt, cnt_d;
    logic [7:0]              csum, csum_d;
    logic [TW-1:0]           tcnt, tcnt_d;
    logic [NCOEF-1:0][31:0]  shadow, shadow_d;
    logic [NCOEF-1:0][31:0]  coef, coef_d;
    logic                    rdy, rdy_d;
    logic                    upd_d, err_d, busy_d;
    logic [1:0]              code_d;
    logic                    acc;

    assign acc          = bus.in_valid & rdy;
    assign bus.in_ready = rdy;

    assign b0 = coef[0];
    assign b1 = coef[1];
    assign b2 = coef[2];
    assign a0 = coef[3];
    assign a1 = coef[4];
    assign a2 = coef[5];

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        csum_d   = csum;
        tcnt_d   = tcnt;
        shadow_d = shadow;
        coef_d   = coef;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        code_d   = err_code;

        case (state)
            S_IDLE: begin
                if (acc && (bus.in_data == SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = 5'd0;
                    csum_d  = 8'd0;
                    tcnt_d  = '0;
                end
            end

            S_PAYLOAD: begin
                if (acc) begin
                    shadow_d[cnt[4:2]] = {shadow[cnt[4:2]][23:0], bus.in_data};
                    csum_d = csum ^ bus.in_data;
                    cnt_d  = cnt + 5'd1;
                    tcnt_d = '0;
                    if (cnt == LAST_PAYLOAD) begin
                        state_d = S_CHECK;
                    end
                end else if (tcnt == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end

            S_CHECK: begin
                if (acc) begin
                    tcnt_d = '0;
                    if (bus.in_data == csum) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end else if (tcnt == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end

            S_COMMIT: begin
                coef_d  = shadow;
                upd_d   = 1'b1;
                code_d  = ERR_NONE;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d  = (state_d != S_COMMIT);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            csum         <= 8'd0;
            tcnt         <= '0;
            shadow       <= '0;
            coef         <= COEF_RST;
            rdy          <= 1'b1;
            busy         <= 1'b0;
            coeff_update <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            csum         <= csum_d;
            tcnt         <= tcnt_d;
            shadow       <= shadow_d;
            coef         <= coef_d;
            rdy          <= rdy_d;
            busy         <= busy_d;
            coeff_update <= upd_d;
            frame_err    <= err_d;
            err_code     <= code_d;
        end
    end
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Randomised bench for biquad_coeff_loader: frame-level reference model with
// per-cycle comparison plus literal spot checks.
module tb_biquad_coeff_loader;
    localparam int unsigned TO   = 40;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef logic [5:0][31:0] cset_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    biquad_coeff_loader_if bus ();

    logic [31:0] b0, b1, b2, a0, a1, a2;
    logic        coeff_update, frame_err, busy;
    logic [1:0]  err_code;

    biquad_coeff_loader #(
        .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO),
        .RST_B0(32'd1), .RST_A0(32'd10000), .RST_OTHER(32'd0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .b0(b0), .b1(b1), .b2(b2), .a0(a0), .a1(a1), .a2(a2),
        .coeff_update(coeff_update), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: collects the frame as a byte list, decides at the checksum byte
    cset_t      m_coef, m_pend;
    logic       m_ready, m_busy, m_upd, m_err, m_pending, m_acc;
    logic [1:0] m_code;
    logic [7:0] m_frame [$];
    logic [7:0] m_x;
    int         m_idle;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_coef    = {32'd0, 32'd0, 32'd10000, 32'd0, 32'd0, 32'd1};
            m_pend    = '0;
            m_ready   = 1'b1;
            m_busy    = 1'b0;
            m_upd     = 1'b0;
            m_err     = 1'b0;
            m_pending = 1'b0;
            m_code    = 2'd0;
            m_idle    = 0;
            m_frame.delete();
        end else begin
            m_upd = 1'b0;
            m_err = 1'b0;
            m_acc = bus.in_valid && m_ready;
            if (m_pending) begin
                m_coef    = m_pend;
                m_upd     = 1'b1;
                m_code    = 2'd0;
                m_pending = 1'b0;
                m_ready   = 1'b1;
                m_busy    = 1'b0;
            end else if (m_frame.size() == 0) begin
                if (m_acc && bus.in_data == SYNC) begin
                    m_frame.push_back(bus.in_data);
                    m_idle = 0;
                    m_busy = 1'b1;
                end
            end else if (m_acc) begin
                m_idle = 0;
                if (m_frame.size() < 25) begin
                    m_frame.push_back(bus.in_data);
                end else begin
                    m_x = 8'd0;
                    for (int i = 1; i <= 24; i++) m_x = m_x ^ m_frame[i];
                    if (m_x == bus.in_data) begin
                        for (int k = 0; k < 6; k++)
                            m_pend[k] = {m_frame[1+4*k], m_frame[2+4*k], m_frame[3+4*k], m_frame[4+4*k]};
                        m_pending = 1'b1;
                        m_ready   = 1'b0;
                    end else begin
                        m_err  = 1'b1;
                        m_code = 2'd1;
                        m_busy = 1'b0;
                    end
                    m_frame.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err  = 1'b1;
                    m_code = 2'd2;
                    m_busy = 1'b0;
                    m_frame.delete();
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge, plus pulse counters
    logic rdy_neg  = 1'b1;
    int   upd_seen = 0;
    int   err_seen = 0;

    always @(negedge clk) begin
        rdy_neg = bus.in_ready;
        if (coeff_update === 1'b1) upd_seen++;
        if (frame_err === 1'b1) err_seen++;
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("coeff_update", 32'(coeff_update), 32'(m_upd));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("b0", b0, m_coef[0]);
        chk("b1", b1, m_coef[1]);
        chk("b2", b2, m_coef[2]);
        chk("a0", a0, m_coef[3]);
        chk("a1", a1, m_coef[4]);
        chk("a2", a2, m_coef[5]);
    end

    function automatic logic [7:0] csum_of(input cset_t c);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 4; j++) x = x ^ c[k][31-8*j -: 8];
        return x;
    endfunction

    function automatic cset_t rand_set();
        cset_t c;
        for (int k = 0; k < 6; k++) c[k] = $urandom;
        return c;
    endfunction

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        forever begin
            @(posedge clk);
            n++;
            if (rdy_neg) break;
            if (n >= 8) begin
                n_chk++;
                $display("FAIL send_byte: byte %0h not accepted within %0d cycles", d, n);
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    // gmode: 0 no gaps, 1 occasional random gaps below the timeout, 2 gap of TO-1 every byte
    task automatic gap(input int gmode);
        if (gmode == 1) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, TO - 1)));
        end else if (gmode == 2) begin
            idle(TO - 1);
        end
    endtask

    task automatic send_partial(input cset_t c, input int nbytes);
        send_byte(SYNC);
        for (int i = 0; i < nbytes; i++) send_byte(c[i/4][31-8*(i%4) -: 8]);
    endtask

    task automatic send_frame(input cset_t c, input bit bad, input int gmode);
        send_byte(SYNC);
        gap(gmode);
        for (int i = 0; i < 24; i++) begin
            send_byte(c[i/4][31-8*(i%4) -: 8]);
            gap(gmode);
        end
        send_byte(csum_of(c) ^ (bad ? 8'h01 : 8'h00));
    endtask

    task automatic chk_set(input string tag, input cset_t c);
        chk({tag, "_b0"}, b0, c[0]);
        chk({tag, "_b1"}, b1, c[1]);
        chk({tag, "_b2"}, b2, c[2]);
        chk({tag, "_a0"}, a0, c[3]);
        chk({tag, "_a1"}, a1, c[4]);
        chk({tag, "_a2"}, a2, c[5]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cset_t g, c;
        int    n_good, n_bad;
        bit    bad;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_set("rst", {32'd0, 32'd0, 32'd10000, 32'd0, 32'd0, 32'd1});
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        @(posedge clk);
        #1;

        // Good frame
        g = {32'h00000FA0, 32'hFFFFD8F0, 32'h00002710, 32'h00002710, 32'h00004E20, 32'h00002710};
        chk("csum_pin", 32'(csum_of(g)), 32'h000000DE);
        upd_seen = 0; err_seen = 0;
        send_frame(g, 1'b0, 0);
        idle(3);
        chk_set("good", {32'd4000, 32'hFFFFD8F0, 32'd10000, 32'd10000, 32'd20000, 32'd10000});
        chk("good_upd", 32'(upd_seen), 32'd1);
        chk("good_err", 32'(err_seen), 32'd0);
        chk("good_code", 32'(err_code), 32'd0);

        // Bad checksum
        upd_seen = 0; err_seen = 0;
        send_frame(g, 1'b1, 0);
        idle(3);
        chk("bad_err", 32'(err_seen), 32'd1);
        chk("bad_upd", 32'(upd_seen), 32'd0);
        chk("bad_code", 32'(err_code), 32'd1);
        chk_set("bad_keep", g);

        // Timeout: boundary then expiry
        err_seen = 0;
        send_partial(g, 10);
        idle(TO - 1);
        chk("to_busy_pre", 32'(busy), 32'd1);
        chk("to_err_pre", 32'(err_seen), 32'd0);
        idle(1);
        chk("to_pulse", 32'(frame_err), 32'd1);
        chk("to_code", 32'(err_code), 32'd2);
        chk("to_busy", 32'(busy), 32'd0);
        idle(2);
        c = rand_set();
        send_frame(c, 1'b0, 0);
        idle(3);
        chk("to_recover_code", 32'(err_code), 32'd0);
        chk_set("to_recover", c);

        // Byte arrives on the edge the timeout would fire: byte wins
        upd_seen = 0; err_seen = 0;
        c = rand_set();
        send_frame(c, 1'b0, 2);
        idle(3);
        chk("edge_upd", 32'(upd_seen), 32'd1);
        chk("edge_err", 32'(err_seen), 32'd0);
        chk_set("edge", c);

        // Junk before sync, sync values inside payload, throttled
        upd_seen = 0; err_seen = 0;
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        idle(2);
        chk("junk_busy", 32'(busy), 32'd0);
        chk("junk_err", 32'(err_seen), 32'd0);
        c = rand_set();
        c[1] = {16'hA5A5, c[1][15:0]};
        c[4][7:0] = SYNC;
        send_frame(c, 1'b0, 1);
        idle(3);
        chk("junk_upd", 32'(upd_seen), 32'd1);
        chk("junk_err2", 32'(err_seen), 32'd0);
        chk_set("junk", c);

        // Random frames, mixed good/bad, back-to-back or throttled
        upd_seen = 0; err_seen = 0; n_good = 0; n_bad = 0;
        for (int f = 0; f < 10; f++) begin
            c   = rand_set();
            bad = ($urandom_range(0, 2) == 0);
            if (bad) n_bad++; else n_good++;
            send_frame(c, bad, int'($urandom_range(0, 1)));
        end
        idle(3);
        chk("rand_upd", 32'(upd_seen), 32'(n_good));
        chk("rand_err", 32'(err_seen), 32'(n_bad));

        // Async reset mid-payload
        c = rand_set();
        send_frame(c, 1'b0, 0);
        idle(3);
        upd_seen = 0; err_seen = 0;
        g = rand_set();
        send_partial(g, 12);
        #2 rst = 1'b1;
        #1;
        chk_set("arst", {32'd0, 32'd0, 32'd10000, 32'd0, 32'd0, 32'd1});
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_code", 32'(err_code), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_pulses", 32'(upd_seen + err_seen), 32'd0);
        send_frame(g, 1'b0, 0);
        idle(3);
        chk("arst_upd", 32'(upd_seen), 32'd1);
        chk_set("arst_frame", g);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
